envia_movimentos: RTL

- Transmit-side counterpart of the move reception path.
- Reads the move RAM from address 0 upward. Each 3-bit move code is sent back to the PC over UART as an ASCII digit, so the host can verify the stored sequence before servos run.
- Stops at the first 000 terminator or after MAX_MOVES entries, then sends an end marker and pulses pronto.
- Sits beside the move receiver in the top datapath. It shares the move RAM address bus through the existing sel_movimento-style mux and the serial output through the sel_serial mux.

---
 rtl/envia_movimentos_pkg.sv | 25 ++
 rtl/envia_movimentos_tx_serial_8n1.sv | 71 +++++++
 rtl/envia_movimentos.sv | 122 ++++++++++++
 3 files changed

// File: rtl/envia_movimentos_pkg.sv
// rtl/envia_movimentos_pkg.sv - shared serial constants and FSM encodings for the move transmitter
package envia_movimentos_pkg;

    localparam int CLKS_PER_BIT_DEF = 434;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] END_MARKER = 8'h23;

    typedef enum logic [3:0] {
        INICIAL    = 4'd0,
        LE_RAM     = 4'd1,
        ESPERA_RAM = 4'd2,
        CARREGA    = 4'd3,
        TRANSMITE  = 4'd4,
        PROXIMO    = 4'd5,
        ENVIA_FIM  = 4'd6,
        ESPERA_FIM = 4'd7,
        FINAL      = 4'd8
    } estado_t;

    function automatic logic [7:0] codifica_movimento(input logic [2:0] codigo);
        return ASCII_ZERO + {5'd0, codigo};
    endfunction

endpackage

// File: rtl/envia_movimentos_tx_serial_8n1.sv
// rtl/envia_movimentos_tx_serial_8n1.sv - 8N1 UART transmitter, LSB first, idle high
module tx_serial_8n1
    import envia_movimentos_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dados,
    output logic       saida_serial,
    output logic       pronto_tx,
    output logic       ocupado
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    // quadro_q[0] is the line itself; shifting in ones leaves the line idle after the stop bit.
    logic [9:0]       quadro_q, quadro_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic             ocupado_q, ocupado_d;
    logic             fim_bit;

    assign fim_bit = (cnt_q == CNT_MAX);

    always_comb begin
        quadro_d  = quadro_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        ocupado_d = ocupado_q;
        if (!ocupado_q) begin
            if (partida) begin
                quadro_d  = {1'b1, dados, 1'b0};
                cnt_d     = '0;
                bit_d     = 4'd0;
                ocupado_d = 1'b1;
            end
        end else if (fim_bit) begin
            cnt_d    = '0;
            quadro_d = {1'b1, quadro_q[9:1]};
            if (bit_q == 4'd9) begin
                ocupado_d = 1'b0;
            end else begin
                bit_d = bit_q + 4'd1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            quadro_q  <= '1;
            cnt_q     <= '0;
            bit_q     <= 4'd0;
            ocupado_q <= 1'b0;
        end else begin
            quadro_q  <= quadro_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign saida_serial = quadro_q[0];
    assign pronto_tx    = ocupado_q && fim_bit && (bit_q == 4'd9);
    assign ocupado      = ocupado_q;

endmodule

// File: rtl/envia_movimentos.sv
// rtl/envia_movimentos.sv - replays the stored move sequence to the host as ASCII digits over UART
module envia_movimentos
    import envia_movimentos_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int ADDR_W       = 9,
    parameter int MAX_MOVES    = 480
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [2:0]        movimento,
    output logic [ADDR_W-1:0] addr,
    output logic              saida_serial,
    output logic              pronto,
    output logic [ADDR_W-1:0] contagem,
    output logic [3:0]        db_estado
);

    localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(MAX_MOVES - 1);

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] contagem_q, contagem_d;
    logic [7:0]        byte_q, byte_d;
    logic              partida_q, partida_d;
    logic              pronto_q, pronto_d;
    logic              tx_pronto;
    logic              tx_ocupado;

    tx_serial_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clock       (clock),
        .reset       (reset),
        .partida     (partida_q),
        .dados       (byte_q),
        .saida_serial(saida_serial),
        .pronto_tx   (tx_pronto),
        .ocupado     (tx_ocupado)
    );

    // partida and pronto are raised on the transition so they are high exactly in CARREGA/ENVIA_FIM/FINAL.
    always_comb begin
        estado_d   = estado_q;
        addr_d     = addr_q;
        contagem_d = contagem_q;
        byte_d     = byte_q;
        partida_d  = 1'b0;
        pronto_d   = 1'b0;
        case (estado_q)
            INICIAL: begin
                if (iniciar && !tx_ocupado) begin
                    addr_d     = '0;
                    contagem_d = '0;
                    estado_d   = LE_RAM;
                end
            end
            LE_RAM: estado_d = ESPERA_RAM;
            ESPERA_RAM: begin
                partida_d = 1'b1;
                if (movimento == 3'd0) begin
                    byte_d   = END_MARKER;
                    estado_d = ENVIA_FIM;
                end else begin
                    byte_d   = codifica_movimento(movimento);
                    estado_d = CARREGA;
                end
            end
            CARREGA: estado_d = TRANSMITE;
            TRANSMITE: begin
                if (tx_pronto) begin
                    contagem_d = contagem_q + 1'b1;
                    estado_d   = PROXIMO;
                end
            end
            PROXIMO: begin
                if (addr_q == ULTIMO) begin
                    byte_d    = END_MARKER;
                    partida_d = 1'b1;
                    estado_d  = ENVIA_FIM;
                end else begin
                    addr_d   = addr_q + 1'b1;
                    estado_d = LE_RAM;
                end
            end
            ENVIA_FIM: estado_d = ESPERA_FIM;
            ESPERA_FIM: begin
                if (tx_pronto) begin
                    pronto_d = 1'b1;
                    estado_d = FINAL;
                end
            end
            FINAL:   estado_d = INICIAL;
            default: estado_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= INICIAL;
            addr_q     <= '0;
            contagem_q <= '0;
            byte_q     <= 8'h00;
            partida_q  <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            addr_q     <= addr_d;
            contagem_q <= contagem_d;
            byte_q     <= byte_d;
            partida_q  <= partida_d;
            pronto_q   <= pronto_d;
        end
    end

    assign addr      = addr_q;
    assign contagem  = contagem_q;
    assign pronto    = pronto_q;
    assign db_estado = estado_q;

endmodule
